alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 2, meaning EXEC cycles spent on a multiply (ctrl 4'b0101), legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL have ports reqN_valid  input  1, reqN_ready  output  1, reqN_src1  input  32, reqN_src2  input  32, reqN_ctrl  input  4, for N = 0,1: request channels.
REQ-005 The block SHALL have ports rspN_valid  output  1, rspN_ready  input  1, rspN_result  output  32, rspN_zero  output  1, for N = 0,1: response channels.
REQ-006 The block SHALL have ports alu_src1_o  output  32, alu_src2_o  output  32, alu_ctrl_o  output  4, alu_result_i  input  32, alu_zero_i  input  1: shared ALU connection; the ALU is purely combinational.

Function
REQ-007 The FSM SHALL have states IDLE, EXEC, RESP; one transaction is in flight at a time.
REQ-008 IDLE: grant SHALL select among asserted reqN_valid; reqN_ready SHALL be asserted combinationally only in IDLE and only for the granted N; never both readies high.
REQ-009 On the accepting edge (valid and ready high) the block SHALL latch src1, src2, ctrl and grant index into registers and enter EXEC.
REQ-010 alu_src1_o/alu_src2_o/alu_ctrl_o SHALL be driven from the latched registers, stable for all of EXEC; outside EXEC they SHALL be zero.
REQ-011 EXEC SHALL last 1 cycle for any ctrl except 4'b0101, and MUL_LAT cycles for 4'b0101, counted by a 4-bit down-counter loaded at accept.
REQ-012 On the last EXEC edge the block SHALL capture alu_result_i and alu_zero_i into result/zero registers and enter RESP.
REQ-013 RESP: rspN_valid SHALL be high for the granted N only, with rspN_result/rspN_zero held stable until rspN_ready; the other rsp channel's valid SHALL stay 0.
REQ-014 On the edge where rspN_valid and rspN_ready are both high the block SHALL return to IDLE; a new request SHALL be accepted no earlier than the following cycle (no bypass).
REQ-015 Latency: rspN_valid first high 2 cycles after accept for non-multiply, 1+MUL_LAT cycles after accept for multiply.
REQ-016 Round-robin: a last_grant register SHALL update on each accept; with both valid in IDLE, grant SHALL go to the requester not granted last; after reset requester 0 wins a tie.
REQ-017 A requester whose valid drops while not granted SHALL lose nothing; the block SHALL not latch unaccepted data.
REQ-018 rspN_result/rspN_zero SHALL read zero when rspN_valid is low.
REQ-019 ctrl codes SHALL be passed through unmodified; undefined codes (1000-1101) execute in 1 cycle and return whatever the ALU produces.

Reset
REQ-020 With rst high at a clock edge, state SHALL become IDLE, last_grant 1 (so requester 0 wins first tie), counter 0, latched operands/result/zero 0.
REQ-021 During and after reset all outputs SHALL be 0 (readies, rsp valids, ALU drive); rst asserted mid-EXEC or mid-RESP SHALL abort the transaction with no response issued.
REQ-022 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-023 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win a tie and last_grant SHALL be unused; when undefined, REQ-016 round-robin applies.

Verification
REQ-024 Reset, then req0 add 5+7 (ctrl 0010) alone, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, result 12, zero 0; rsp1_valid never high.
REQ-025 req1 sub 9-9 (ctrl 0110) -> rsp1_result 0, rsp1_zero 1.
REQ-026 req0 mul 3*4 (ctrl 0101), MUL_LAT=2 -> alu_ctrl_o 0101 for exactly 2 cycles, rsp0_valid 3 cycles after accept, result 12.
REQ-027 Both valid continuously, 4 transactions, macro undefined -> grants 0,1,0,1; macro defined -> grants 0,0,0,0.
REQ-028 rsp0_ready held low 5 cycles -> rsp0_valid/result stable 5 cycles, req1_ready stays 0; release -> IDLE next cycle.
REQ-029 rst pulsed during multiply EXEC -> all outputs 0 next cycle, no rsp issued; next request serviced normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
//
// Purpose:
//   Two request/response channels share a single combinational ALU. One
//   transaction is in flight at a time (IDLE -> EXEC -> RESP). Multiplies
//   (ctrl 4'b0101) occupy EXEC for MUL_LAT cycles, every other code for one.
//   Ties between requesters are broken round-robin, or with fixed priority
//   to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN - requester 0 always wins a tie; last_grant removed.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/ready/src1/src2/ctrl   request channel N (N = 0,1)
//   rspN_valid/ready/result/zero      response channel N (N = 0,1)
//   alu_src1_o/alu_src2_o/alu_ctrl_o  operands to the shared ALU (zero outside EXEC)
//   alu_result_i/alu_zero_i           shared ALU outputs

module alu_share_arbiter #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic [3:0]  req0_ctrl,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    input  logic [3:0]  req1_ctrl,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,

    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_MUL     = 4'b0101;
    // Counter holds "remaining EXEC cycles minus one", so EXEC ends when it reads 0.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;

    logic        grant_idx;
    logic        accept;
    logic [3:0]  sel_ctrl;

    // Grant selection: grant_idx is only meaningful while some valid is high.
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_idx = !req0_valid;
    end
`else
    logic last_grant_q, last_grant_d;

    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = req1_valid;
        end
    end

    assign last_grant_d = accept ? grant_idx : last_grant_q;

    // Reset to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Readies depend only on IDLE and the current valids; nothing is latched
    // unless the accepting edge actually occurs.
    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid) && !rst;
    assign req0_ready = accept && !grant_idx;
    assign req1_ready = accept && grant_idx;
    assign sel_ctrl   = grant_idx ? req1_ctrl : req0_ctrl;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d   = grant_idx;
                    src1_d  = grant_idx ? req1_src1 : req0_src1;
                    src2_d  = grant_idx ? req1_src2 : req0_src2;
                    ctrl_d  = sel_ctrl;
                    cnt_d   = (sel_ctrl == CTRL_MUL) ? MUL_CNT_INIT : 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    result_d = alu_result_i;
                    zero_d   = alu_zero_i;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (gnt_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            src1_q   <= 32'd0;
            src2_q   <= 32'd0;
            ctrl_q   <= 4'd0;
            cnt_q    <= 4'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Outputs are also gated by rst so they read zero while reset is held,
    // including before the first reset edge has been seen.
    logic exec_drv;
    assign exec_drv   = (state_q == EXEC) && !rst;
    assign alu_src1_o = exec_drv ? src1_q : 32'd0;
    assign alu_src2_o = exec_drv ? src2_q : 32'd0;
    assign alu_ctrl_o = exec_drv ? ctrl_q : 4'd0;

    assign rsp0_valid  = (state_q == RESP) && !gnt_q && !rst;
    assign rsp1_valid  = (state_q == RESP) && gnt_q && !rst;
    assign rsp0_result = rsp0_valid ? result_q : 32'd0;
    assign rsp0_zero   = rsp0_valid ? zero_q : 1'b0;
    assign rsp1_result = rsp1_valid ? result_q : 32'd0;
    assign rsp1_zero   = rsp1_valid ? zero_q : 1'b0;

endmodule
